// File: rtl/rrarb_pkg.sv
// Shared types and helpers for the burst-aware round-robin scheduler.
package rrarb_pkg;

  localparam int MAX_BEATS_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int rr_idx_w(input int n);
    return $clog2(n);
  endfunction

  // Index of the set bit in a one-hot vector; zero when nothing is set.
  function automatic int oh2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rrarb_rr_pick.sv
// Combinational round-robin picker: lowest set request at or after ptr+1,
// found by masking a doubled request vector and isolating its lowest bit.
module rrarb_rr_pick
  import rrarb_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int IW      = rr_idx_w(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [REQ_CNT-1:0] pick_oh_o,
  output logic [IW-1:0]      pick_idx_o
);

  logic [2*REQ_CNT-1:0] dbl;
  logic [2*REQ_CNT-1:0] masked;
  logic [2*REQ_CNT-1:0] lowest;
  logic [IW:0]          start;

  always_comb begin
    dbl    = {req_i, req_i};
    start  = (ptr_i == IW'(REQ_CNT - 1)) ? '0 : ({1'b0, ptr_i} + 1'b1);
    masked = dbl & ({(2*REQ_CNT){1'b1}} << start);
    lowest = masked & (~masked + 1'b1);
    // Fold the upper copy back so wrap-around winners land on their own index.
    pick_oh_o  = lowest[REQ_CNT-1:0] | lowest[2*REQ_CNT-1:REQ_CNT];
    pick_idx_o = IW'(oh2idx(32'(pick_oh_o)));
  end

endmodule

// File: rtl/rrarb_burst_sched.sv
// Burst-aware round-robin scheduler with registered one-hot grant.
// Optional per-requester quantum via `define RRARB_WEIGHT_EN.
module rrarb_burst_sched
  import rrarb_pkg::*;
#(
  parameter int REQ_CNT   = 4,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int WW        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_CNT-1:0]    req,
  input  logic [REQ_CNT-1:0]    req_last,
  input  logic                  rsrc_ready,
  input  logic [REQ_CNT*WW-1:0] weight,
  output logic [REQ_CNT-1:0]    grant,
  output logic [REQ_CNT-1:0]    beat_ack,
  output logic                  busy
);

  localparam int IW = rr_idx_w(REQ_CNT);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic [REQ_CNT-1:0] grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]      quantum_q, quantum_d;
  logic               busy_q;

  state_e             state;
  logic               req_g, last_g, accepted, rel, load;
  logic [CW-1:0]      cnt_inc;
  logic [REQ_CNT-1:0] req_next;
  logic [REQ_CNT-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic [CW-1:0]      quantum_ld;

  assign state    = (|grant_q) ? ST_HOLD : ST_IDLE;
  assign req_g    = |(grant_q & req);
  assign last_g   = |(grant_q & req_last);
  assign accepted = req_g & rsrc_ready;
  assign cnt_inc  = beat_cnt_q + 1'b1;
  assign rel      = (state == ST_HOLD) &
                    ((accepted & last_g) | (accepted & (cnt_inc == quantum_q)) | ~req_g);
  // A requester that let go of req is not eligible for the handover pick.
  assign req_next = (state == ST_HOLD && !req_g) ? (req & ~grant_q) : req;
  assign load     = ((state == ST_IDLE) | rel) & (|req_next);

  rrarb_rr_pick #(
    .REQ_CNT (REQ_CNT),
    .IW      (IW)
  ) u_pick (
    .req_i      (req_next),
    .ptr_i      (ptr_q),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx)
  );

`ifdef RRARB_WEIGHT_EN
  logic [WW-1:0] w_sel;
  assign w_sel = weight[int'(pick_idx)*WW +: WW];
  always_comb begin
    if (w_sel == '0)
      quantum_ld = CW'(1);
    else if (32'(w_sel) > 32'(MAX_BEATS))
      quantum_ld = CW'(MAX_BEATS);
    else
      quantum_ld = CW'(w_sel);
  end
`else
  logic unused_weight;
  assign unused_weight = ^weight;
  assign quantum_ld    = CW'(MAX_BEATS);
`endif

  always_comb begin
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    quantum_d  = quantum_q;
    if (load) begin
      grant_d    = pick_oh;
      ptr_d      = pick_idx;
      beat_cnt_d = '0;
      quantum_d  = quantum_ld;
    end else if (rel) begin
      grant_d    = '0;
      beat_cnt_d = '0;
    end else if (accepted) begin
      beat_cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      ptr_q      <= IW'(REQ_CNT - 1);
      beat_cnt_q <= '0;
      quantum_q  <= CW'(MAX_BEATS);
      busy_q     <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      quantum_q  <= quantum_d;
      busy_q     <= |grant_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign beat_ack = grant_q & req & {REQ_CNT{rsrc_ready}};

endmodule

// File: tb/tb_rrarb_burst_sched.sv
// Directed scoreboard bench for rrarb_burst_sched (REQ_CNT=4, MAX_BEATS=4).
module tb_rrarb_burst_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_last;
  logic        rsrc_ready;
  logic [31:0] weight;
  logic [3:0]  grant, beat_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  rrarb_burst_sched #(.REQ_CNT(4), .MAX_BEATS(4), .WW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_last   (req_last),
    .rsrc_ready (rsrc_ready),
    .weight     (weight),
    .grant      (grant),
    .beat_ack   (beat_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check beat_ack now, then grant/busy after the edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] l,
                     input logic rdy, input logic [3:0] ack_e, input logic [3:0] g_next);
    logic [3:0] g;
    req = r; req_last = l; rsrc_ready = rdy;
    #1;
    chk({tag, "_ack"}, 32'(beat_ack), 32'(ack_e));
    exp_q.push_back(g_next);
    @(posedge clk); #1;
    g = exp_q.pop_front();
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'(|g));
  endtask

  task automatic do_reset();
    req = '0; req_last = '0; rsrc_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] g_now, g_nx;
    req = '0; req_last = '0; rsrc_ready = 1'b0;
    weight = {4{8'd4}};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single requester, last on third beat, then drop.
    cyc("single_idle", 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0001);
    cyc("single_b1",   4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001);
    cyc("single_b2",   4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001);
    cyc("single_b3",   4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    cyc("single_drop", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
    cyc("single_idle2",4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    // Quantum fairness: four beats each, no idle gap.
    do_reset();
    cyc("fair_idle", 4'hF, 4'h0, 1'b1, 4'b0000, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      g_now = 4'b0001 << ((k / 4) % 4);
      g_nx  = 4'b0001 << (((k + 1) / 4) % 4);
      cyc("fair", 4'hF, 4'h0, 1'b1, g_now, g_nx);
    end

    // Stall on requester 1 after one beat; remaining three beats follow.
    cyc("stall_b1", 4'hF, 4'h0, 1'b1, 4'b0010, 4'b0010);
    for (int k = 0; k < 10; k++)
      cyc("stall_hold", 4'hF, 4'h0, 1'b0, 4'b0000, 4'b0010);
    cyc("stall_b2", 4'hF, 4'h0, 1'b1, 4'b0010, 4'b0010);
    cyc("stall_b3", 4'hF, 4'h0, 1'b1, 4'b0010, 4'b0010);
    cyc("stall_b4", 4'hF, 4'h0, 1'b1, 4'b0010, 4'b0100);

    // Drop: holder releases by lowering req; then req[1] falls mid-burst.
    cyc("drop_hand", 4'b0010, 4'h0, 1'b1, 4'b0000, 4'b0010);
    cyc("drop_b1",   4'b0010, 4'h0, 1'b1, 4'b0010, 4'b0010);
    cyc("drop_r1",   4'b1000, 4'h0, 1'b1, 4'b0000, 4'b1000);
    cyc("drop_ptr3", 4'b1001, 4'b1000, 1'b1, 4'b1000, 4'b0001);

    // Asynchronous reset mid-burst.
    cyc("rst_b1", 4'b0001, 4'h0, 1'b1, 4'b0001, 4'b0001);
    req = 4'b0001; req_last = 4'h0; rsrc_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_ack", 32'(beat_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'hF;
    @(posedge clk); #1;
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_busy", 32'(busy), 32'h1);
    cyc("post_rst_b2", 4'hF, 4'h0, 1'b1, 4'b0001, 4'b0001);

`ifdef RRARB_WEIGHT_EN
    begin
      logic [3:0] seq[$];
      int lens[4] = '{4, 1, 2, 1};
      weight = {8'd0, 8'd2, 8'd1, 8'd9};
      do_reset();
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 4; i++)
          for (int b = 0; b < lens[i]; b++)
            seq.push_back(4'b0001 << i);
      seq.push_back(4'b0001);
      cyc("wt_idle", 4'hF, 4'h0, 1'b1, 4'b0000, 4'b0001);
      for (int k = 0; k < seq.size() - 1; k++)
        cyc("wt", 4'hF, 4'h0, 1'b1, seq[k], seq[k+1]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
